// File: rtl/reset_seq_pkg.sv
// Shared types and default timing constants for the reset release sequencer.
package reset_seq_pkg;

  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_STAGE_DELAY = 16;

  typedef enum logic [2:0] {
    HOLD        = 3'd0,
    WAIT_PERIPH = 3'd1,
    WAIT_TILE   = 3'd2,
    WAIT_CORE   = 3'd3,
    RUN         = 3'd4
  } seq_state_e;

endpackage

// File: rtl/reset_release_sequencer_sync.sv
// reset_sync: async-assert, sync-deassert chain; sync_ok rises on the
// SYNC_STAGES-th rising edge after reset_n is released.
module reset_sync
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset_n,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases periph, tile, core resets in order, STAGE_DELAY cycles apart.
// RESET_SEQ_DEBUG_HOLD_EN adds debug_hold to park the sequence in WAIT_CORE.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY
) (
  input  logic clock,
  input  logic reset_n,
  input  logic soft_reset_req,
  output logic periph_reset,
  output logic tile_reset,
  output logic core_reset,
  output logic reset_done
`ifdef RESET_SEQ_DEBUG_HOLD_EN
  ,
  input  logic debug_hold
`endif
);

  localparam int CW = $clog2(STAGE_DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STAGE_DELAY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_ok;
  seq_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          periph_nx, tile_nx, core_nx, done_nx;
  logic          core_go;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .sync_ok (sync_ok)
  );

  // Leaving WAIT_CORE: normally at the last count; with debug hold the
  // counter may sit saturated until the hold drops.
`ifdef RESET_SEQ_DEBUG_HOLD_EN
  assign core_go = ((cnt == CNT_LAST) || (cnt == CNT_SAT)) && !debug_hold;
`else
  assign core_go = (cnt == CNT_LAST);
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    periph_nx = periph_reset;
    tile_nx   = tile_reset;
    core_nx   = core_reset;
    done_nx   = reset_done;
    case (state)
      HOLD: begin
        if (sync_ok) begin
          state_nx = WAIT_PERIPH;
          cnt_nx   = '0;
        end
      end
      WAIT_PERIPH: begin
        if (cnt == CNT_LAST) begin
          periph_nx = 1'b0;
          state_nx  = WAIT_TILE;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      WAIT_TILE: begin
        if (cnt == CNT_LAST) begin
          tile_nx  = 1'b0;
          state_nx = WAIT_CORE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      WAIT_CORE: begin
        if (core_go) begin
          core_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = RUN;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST || cnt == CNT_SAT) begin
          cnt_nx = CNT_SAT;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      RUN: begin
        // Soft reset restarts tile and core only; periph stays released.
        if (soft_reset_req) begin
          tile_nx  = 1'b1;
          core_nx  = 1'b1;
          done_nx  = 1'b0;
          state_nx = WAIT_TILE;
          cnt_nx   = '0;
        end
      end
      default: begin
        periph_nx = 1'b1;
        tile_nx   = 1'b1;
        core_nx   = 1'b1;
        done_nx   = 1'b0;
        state_nx  = HOLD;
        cnt_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      cnt          <= '0;
      periph_reset <= 1'b1;
      tile_reset   <= 1'b1;
      core_reset   <= 1'b1;
      reset_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      periph_reset <= periph_nx;
      tile_reset   <= tile_nx;
      core_reset   <= core_nx;
      reset_done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer: default timing, soft reset,
// ignored requests, async reset pulse, and a minimal-delay instance.
module tb_reset_release_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic soft_reset_req = 1'b0;
  logic periph_reset, tile_reset, core_reset, reset_done;
  logic s_periph, s_tile, s_core, s_done;
`ifdef RESET_SEQ_DEBUG_HOLD_EN
  logic debug_hold = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cur = 0;

  always #5 clock = ~clock;

  reset_release_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .soft_reset_req (soft_reset_req),
    .periph_reset   (periph_reset),
    .tile_reset     (tile_reset),
    .core_reset     (core_reset),
    .reset_done     (reset_done)
`ifdef RESET_SEQ_DEBUG_HOLD_EN
    ,
    .debug_hold     (debug_hold)
`endif
  );

  reset_release_sequencer #(.SYNC_STAGES(2), .STAGE_DELAY(1)) u_small (
    .clock          (clock),
    .reset_n        (reset_n),
    .soft_reset_req (1'b0),
    .periph_reset   (s_periph),
    .tile_reset     (s_tile),
    .core_reset     (s_core),
    .reset_done     (s_done)
`ifdef RESET_SEQ_DEBUG_HOLD_EN
    ,
    .debug_hold     (1'b0)
`endif
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ep, input logic et,
                         input logic ec, input logic ed);
    chk({tag, "_periph"}, periph_reset, ep);
    chk({tag, "_tile"},   tile_reset,   et);
    chk({tag, "_core"},   core_reset,   ec);
    chk({tag, "_done"},   reset_done,   ed);
  endtask

  task automatic chk_small(input string tag, input logic ep, input logic et,
                           input logic ec, input logic ed);
    chk({tag, "_s_periph"}, s_periph, ep);
    chk({tag, "_s_tile"},   s_tile,   et);
    chk({tag, "_s_core"},   s_core,   ec);
    chk({tag, "_s_done"},   s_done,   ed);
    chk({tag, "_s_cnt_le1"}, (u_small.cnt <= 1'b1), 1'b1);
  endtask

  // Advance to edge k (edge 0 = first rising edge after reset_n rises), then #1.
  task automatic go(input int k);
    while (cur < k) begin
      @(posedge clock);
      cur++;
    end
    #1;
  endtask

  task automatic start_seq(input string tag);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    chk_out({tag, "_inrst"}, 1'b1, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    cur = -1;
  endtask

  initial begin
    // Default sequence plus the minimal-delay instance alongside it.
    start_seq("seq1");
    go(2);  chk_small("e2", 1'b1, 1'b1, 1'b1, 1'b0);
    go(3);  chk_small("e3", 1'b0, 1'b1, 1'b1, 1'b0);
    go(4);  chk_small("e4", 1'b0, 1'b0, 1'b1, 1'b0);
    go(5);  chk_small("e5", 1'b0, 1'b0, 1'b0, 1'b1);
    go(6);  chk_small("e6", 1'b0, 1'b0, 1'b0, 1'b1);
    go(18); chk_out("e18", 1'b1, 1'b1, 1'b1, 1'b0);
    go(19); chk_out("e19", 1'b0, 1'b1, 1'b1, 1'b0);
    go(34); chk_out("e34", 1'b0, 1'b1, 1'b1, 1'b0);
    go(35); chk_out("e35", 1'b0, 1'b0, 1'b1, 1'b0);
    go(50); chk_out("e50", 1'b0, 1'b0, 1'b1, 1'b0);
    go(51); chk_out("e51", 1'b0, 1'b0, 1'b0, 1'b1);

    // One-cycle soft reset asserted at edge 60; a second request during
    // WAIT_TILE must be dropped, not queued.
    go(60); chk_out("soft_e60", 1'b0, 1'b0, 1'b0, 1'b1);
    soft_reset_req = 1'b1;
    go(61); soft_reset_req = 1'b0;
    chk_out("soft_e61", 1'b0, 1'b1, 1'b1, 1'b0);
    go(70); soft_reset_req = 1'b1;
    go(71); soft_reset_req = 1'b0;
    go(76); chk_out("soft_e76", 1'b0, 1'b1, 1'b1, 1'b0);
    go(77); chk_out("soft_e77", 1'b0, 1'b0, 1'b1, 1'b0);
    go(92); chk_out("soft_e92", 1'b0, 1'b0, 1'b1, 1'b0);
    go(93); chk_out("soft_e93", 1'b0, 1'b0, 1'b0, 1'b1);
    go(110); chk_out("soft_e110", 1'b0, 1'b0, 1'b0, 1'b1);

    // Soft reset held high through WAIT_PERIPH/WAIT_TILE has no effect.
    start_seq("seq2");
    soft_reset_req = 1'b1;
    go(18); chk_out("hold_e18", 1'b1, 1'b1, 1'b1, 1'b0);
    go(19); chk_out("hold_e19", 1'b0, 1'b1, 1'b1, 1'b0);
    go(34); chk_out("hold_e34", 1'b0, 1'b1, 1'b1, 1'b0);
    go(35); chk_out("hold_e35", 1'b0, 1'b0, 1'b1, 1'b0);
    soft_reset_req = 1'b0;
    go(50); chk_out("hold_e50", 1'b0, 1'b0, 1'b1, 1'b0);
    go(51); chk_out("hold_e51", 1'b0, 1'b0, 1'b0, 1'b1);

    // 2 ns async reset pulse at edge 30, then full restart.
    start_seq("seq3");
    go(30); chk_out("pulse_e30", 1'b0, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_out("pulse_async", 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    reset_n = 1'b1;
    cur = -1;
    go(1);  chk_out("re_e1", 1'b1, 1'b1, 1'b1, 1'b0);
    go(18); chk_out("re_e18", 1'b1, 1'b1, 1'b1, 1'b0);
    go(19); chk_out("re_e19", 1'b0, 1'b1, 1'b1, 1'b0);
    go(35); chk_out("re_e35", 1'b0, 1'b0, 1'b1, 1'b0);
    go(51); chk_out("re_e51", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
